rx_packet_sequencer: RTL and testbench
======================================

// Module: rx_packet_sequencer
// PURPOSE
//  Sequences the demodulated receive bitstream into packets. It takes the sliced bit from the matched
//  filter and the bit strobe from timing recovery, then searches for the configured 32-bit access
//  address (AA) with a Hamming-distance tolerance. After a match it frames the 16-bit header and the
//  length-driven payload plus CRC into bytes, which leave through a small valid/ready FIFO.
// PARAMETERS
//  AA_ERR_MAX      2     max mismatched bits accepted on AA match (0..31)
//  FIFO_DEPTH      4     output byte FIFO entries (power of 2, >=2)
//  MAX_PDU_LEN     37    largest legal header length field; larger -> length_err
//  CRC_BYTES       3     bytes appended after PDU payload
//  SEARCH_TIMEOUT  4096  bit strobes in SEARCH before search_timeout pulse; 0 = disabled
// PORTS
//  clk             in   1   16 MHz system clock
//  rst             in   1   asynchronous, active-low reset
//  enable          in   1   1 = receive; 0 = abort to IDLE
//  aa_cfg          in   32  access address; bit 0 is the first bit on air
//  bit_in          in   1   demodulated bit (matched filter data)
//  bit_strobe      in   1   timing-recovery update; rising edge marks bit_in valid
//  byte_out        out  8   FIFO head byte, LSB = first received bit
//  byte_valid      out  1   FIFO non-empty
//  byte_ready      in   1   consumer accepts head when byte_valid & byte_ready
//  pkt_start       out  1   1-cycle pulse on AA match
//  pkt_done        out  1   1-cycle pulse in DONE
//  pkt_abort       out  1   1-cycle pulse when enable drops in HEADER/PAYLOAD
//  search_timeout  out  1   1-cycle pulse on SEARCH timeout
//  length_err      out  1   sticky; set when len > MAX_PDU_LEN, cleared on pkt_start
//  overflow        out  1   sticky; set on byte drop into full FIFO, cleared on pkt_start
//  state_out       out  3   IDLE=0 SEARCH=1 HEADER=2 PAYLOAD=3 DONE=4
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, FIFO empty, AA shift reg and all counters 0.
//  - Strobe detect: strobe_q <= bit_strobe. A bit event is bit_strobe & ~strobe_q; bit_in is sampled on
//    that same clk edge. Bits are consumed only on bit events.
//  - IDLE: if enable=1, go to SEARCH next cycle and clear the AA shift reg and bit count.
//  - SEARCH: sr <= {bit_in, sr[31:1]} and bits_seen saturates at 32.
//    Match = bits_seen==32 & popcount(sr^aa_cfg) <= AA_ERR_MAX, evaluated on the registered sr.
//    On match: HEADER, pkt_start=1, length_err and overflow cleared, byte bit counter reset.
//    Timeout counter counts bit events in SEARCH and resets on entry and on match.
//    When it reaches SEARCH_TIMEOUT: search_timeout pulse, counter restarts, state stays SEARCH.
//  - Byte assembly (HEADER/PAYLOAD): shift bits LSB-first. On the 8th bit, push the byte to the FIFO in
//    the same cycle as that bit event.
//  - HEADER: after byte 2 completes, len = byte 2.
//    If len > MAX_PDU_LEN: set length_err, go to DONE.
//    Else: remaining = len + CRC_BYTES, go to PAYLOAD. If remaining == 0, go straight to DONE.
//  - PAYLOAD: remaining decrements per pushed byte. At 0 go to DONE (last byte already pushed).
//  - DONE: pkt_done=1 for one cycle, then SEARCH if enable else IDLE. Bits arriving in DONE are ignored.
//  - enable=0 in any state: IDLE on the next clk and the partial byte is discarded.
//    In HEADER/PAYLOAD also pulse pkt_abort and flush the FIFO.
//  - FIFO:
//    - Push and pop in the same cycle are always legal, including when full: the pop frees a slot, the
//      byte is stored, and there is no overflow.
//    - A push into a full FIFO with no pop drops the new byte and sets overflow; framing continues.
//    - byte_out/byte_valid are registered from the head pointer; first-word latency is 1 clk after push.
//  - Pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
//  - Popcount is combinational over 32 bits.
// TESTING
//  1 aa_cfg=32'h8E89BED6, stream AA then hdr 0x02,0x03, 3 payload bytes, 3 CRC bytes, byte_ready=1
//    -> pkt_start once; 8 bytes out in order; pkt_done once; state returns to 1.
//  2 same AA with 2 bits flipped -> match; 3 bits flipped -> no pkt_start, state stays 1.
//  3 hdr len=0x40 -> length_err=1, exactly 2 bytes out, pkt_done; next pkt_start clears length_err.
//  4 byte_ready=0 for 8-byte packet, FIFO_DEPTH=4 -> 4 bytes held, overflow=1, pkt_done still pulses;
//    a push+pop on the same cycle while full -> overflow stays 0.
//  5 enable->0 after 12 payload bits -> pkt_abort pulse, byte_valid=0 next clk, state 0.
//  6 SEARCH_TIMEOUT=64, noise only -> search_timeout every 64 strobes; rst low mid-packet -> all outputs 0.

Source files
------------

// File: rtl/rx_packet_sequencer.sv
// rx_packet_sequencer
//
// Purpose:
//   Turns the demodulated receive bitstream into packet bytes. Bits are taken
//   on rising edges of the timing-recovery strobe. In SEARCH the module looks
//   for the configured 32-bit access address and tolerates a limited number of
//   bit errors. After a match it frames the 2-byte header and then the
//   length-driven payload plus CRC into LSB-first bytes. Those bytes leave
//   through a small valid/ready FIFO.
//
// Ports:
//   clk              16 MHz system clock
//   rst              asynchronous, active-low reset
//   i_enable         1 = receive, 0 = abort to IDLE
//   i_aa_cfg         access address, bit 0 is first on air
//   i_bit_in         demodulated bit
//   i_bit_strobe     timing-recovery strobe, rising edge marks i_bit_in valid
//   o_byte_out       FIFO head byte, LSB = first received bit
//   o_byte_valid     FIFO non-empty
//   i_byte_ready     consumer accepts head when valid & ready
//   o_pkt_start      1-cycle pulse on access-address match
//   o_pkt_done       1-cycle pulse while in DONE
//   o_pkt_abort      1-cycle pulse when enable drops mid-packet
//   o_search_timeout 1-cycle pulse after SEARCH_TIMEOUT strobes without a match
//   o_length_err     sticky, header length too large, cleared on pkt_start
//   o_overflow       sticky, byte dropped into a full FIFO, cleared on pkt_start
//   o_state_out      IDLE=0 SEARCH=1 HEADER=2 PAYLOAD=3 DONE=4

module rx_packet_sequencer #(
  parameter int AA_ERR_MAX     = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_PDU_LEN    = 37,
  parameter int CRC_BYTES      = 3,
  parameter int SEARCH_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [31:0] i_aa_cfg,
  input  logic        i_bit_in,
  input  logic        i_bit_strobe,
  output logic [7:0]  o_byte_out,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_pkt_start,
  output logic        o_pkt_done,
  output logic        o_pkt_abort,
  output logic        o_search_timeout,
  output logic        o_length_err,
  output logic        o_overflow,
  output logic [2:0]  o_state_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TO_W  = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = (SEARCH_TIMEOUT > 0) ? TO_W'(SEARCH_TIMEOUT - 1) : '0;
  localparam logic [8:0] CRC_LEN = 9'(CRC_BYTES);
  localparam logic [7:0] MAX_LEN = 8'(MAX_PDU_LEN);
  localparam logic [5:0] ERR_MAX = 6'(AA_ERR_MAX);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_strobe_q;
  logic [31:0]       r_sr;
  logic [5:0]        r_bits_seen;
  logic [TO_W-1:0]   r_to_cnt;
  logic [6:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  logic              r_hdr_second;
  logic [8:0]        r_remaining;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;

  logic              w_bit_ev;
  logic [31:0]       w_diff;
  logic [5:0]        w_pop_cnt;
  logic              w_match;
  logic              w_framing;
  logic [7:0]        w_byte;
  logic [8:0]        w_len_total;
  logic              w_push;
  logic              w_flush;
  logic              w_start;
  logic              w_pop;
  logic              w_full;
  logic              w_write;
  logic              w_drop;
  logic [PTR_W:0]    w_wr_next;
  logic [PTR_W:0]    w_rd_next;
  logic [7:0]        w_head_next;

  assign w_bit_ev    = i_bit_strobe & ~r_strobe_q;
  assign w_diff      = r_sr ^ i_aa_cfg;
  assign w_match     = (r_bits_seen == 6'd32) && (w_pop_cnt <= ERR_MAX);
  assign w_framing   = (r_state == ST_HEADER) || (r_state == ST_PAYLOAD);
  // The byte completes with the bit arriving this cycle, so it can be pushed
  // on the same edge as its 8th bit event.
  assign w_byte      = {i_bit_in, r_shift};
  assign w_len_total = {1'b0, w_byte} + CRC_LEN;
  assign w_push      = i_enable & w_framing & w_bit_ev & (r_bit_cnt == 3'd7);
  assign w_flush     = ~i_enable & w_framing;
  assign w_start     = i_enable & (r_state == ST_SEARCH) & w_match;

  // A pop frees a slot on the same edge, so a push into a full FIFO is only
  // dropped when nothing is being consumed.
  assign w_pop       = o_byte_valid & i_byte_ready;
  assign w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_write     = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;
  assign w_wr_next   = r_wr_ptr + {{PTR_W{1'b0}}, w_write};
  assign w_rd_next   = r_rd_ptr + {{PTR_W{1'b0}}, w_pop};
  // The new head may be the byte being written on this very edge.
  assign w_head_next = (w_write && (w_rd_next[PTR_W-1:0] == r_wr_ptr[PTR_W-1:0]))
                       ? w_byte : r_mem[w_rd_next[PTR_W-1:0]];

  assign o_state_out = r_state;

  // Hamming distance between the search window and the access address
  always_comb begin
    w_pop_cnt = '0;
    for (int i = 0; i < 32; i++) begin
      w_pop_cnt = w_pop_cnt + {5'd0, w_diff[i]};
    end
  end

  // Receive state machine: strobe edge detect, address search, framing and
  // the status pulses/flags it owns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ST_IDLE;
      r_strobe_q       <= 1'b0;
      r_sr             <= '0;
      r_bits_seen      <= '0;
      r_to_cnt         <= '0;
      r_shift          <= '0;
      r_bit_cnt        <= '0;
      r_hdr_second     <= 1'b0;
      r_remaining      <= '0;
      o_pkt_start      <= 1'b0;
      o_pkt_done       <= 1'b0;
      o_pkt_abort      <= 1'b0;
      o_search_timeout <= 1'b0;
      o_length_err     <= 1'b0;
    end else begin
      r_strobe_q       <= i_bit_strobe;
      o_pkt_start      <= 1'b0;
      o_pkt_done       <= 1'b0;
      o_pkt_abort      <= 1'b0;
      o_search_timeout <= 1'b0;
      if (!i_enable) begin
        o_pkt_abort <= w_framing;
        r_state     <= ST_IDLE;
        r_shift     <= '0;
        r_bit_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state     <= ST_SEARCH;
            r_sr        <= '0;
            r_bits_seen <= '0;
            r_to_cnt    <= '0;
          end
          ST_SEARCH: begin
            if (w_match) begin
              r_state      <= ST_HEADER;
              o_pkt_start  <= 1'b1;
              o_length_err <= 1'b0;
              r_bit_cnt    <= '0;
              r_shift      <= '0;
              r_hdr_second <= 1'b0;
              r_to_cnt     <= '0;
            end else if (w_bit_ev) begin
              r_sr <= {i_bit_in, r_sr[31:1]};
              if (r_bits_seen != 6'd32) begin
                r_bits_seen <= r_bits_seen + 6'd1;
              end
              if ((SEARCH_TIMEOUT > 0) && (r_to_cnt == TO_LAST)) begin
                o_search_timeout <= 1'b1;
                r_to_cnt         <= '0;
              end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
              end
            end
          end
          ST_HEADER: begin
            if (w_bit_ev) begin
              r_shift   <= w_byte[7:1];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (!r_hdr_second) begin
                  r_hdr_second <= 1'b1;
                end else if (w_byte > MAX_LEN) begin
                  o_length_err <= 1'b1;
                  o_pkt_done   <= 1'b1;
                  r_state      <= ST_DONE;
                end else if (w_len_total == 9'd0) begin
                  o_pkt_done <= 1'b1;
                  r_state    <= ST_DONE;
                end else begin
                  r_remaining <= w_len_total;
                  r_state     <= ST_PAYLOAD;
                end
              end
            end
          end
          ST_PAYLOAD: begin
            if (w_bit_ev) begin
              r_shift   <= w_byte[7:1];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_remaining <= r_remaining - 9'd1;
                if (r_remaining == 9'd1) begin
                  o_pkt_done <= 1'b1;
                  r_state    <= ST_DONE;
                end
              end
            end
          end
          ST_DONE: begin
            // The search window still holds the old address, so it is
            // cleared to avoid an immediate re-match.
            r_state     <= ST_SEARCH;
            r_sr        <= '0;
            r_bits_seen <= '0;
            r_to_cnt    <= '0;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // FIFO storage, no reset needed since validity comes from the pointers
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= w_byte;
    end
  end

  // FIFO pointers, registered head outputs and the sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      o_byte_valid <= 1'b0;
      o_byte_out   <= '0;
      o_overflow   <= 1'b0;
    end else if (w_flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      o_byte_valid <= 1'b0;
      o_byte_out   <= '0;
    end else begin
      r_wr_ptr     <= w_wr_next;
      r_rd_ptr     <= w_rd_next;
      o_byte_valid <= (w_wr_next != w_rd_next);
      o_byte_out   <= w_head_next;
      if (w_start) begin
        o_overflow <= 1'b0;
      end else if (w_drop) begin
        o_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_packet_sequencer.sv
// tb_rx_packet_sequencer
//
// Purpose:
//   Directed bench for rx_packet_sequencer. Stimulus pushes the bytes it
//   expects to see onto a scoreboard queue. A negedge monitor pops and
//   compares every accepted output byte and counts the status pulses.
//
// Ports: none (top-level bench).

module tb_rx_packet_sequencer;

  localparam logic [31:0] AA = 32'h8E89BED6;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [31:0] i_aa_cfg;
  logic        i_bit_in;
  logic        i_bit_strobe;
  logic [7:0]  o_byte_out;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_pkt_start;
  logic        o_pkt_done;
  logic        o_pkt_abort;
  logic        o_search_timeout;
  logic        o_length_err;
  logic        o_overflow;
  logic [2:0]  o_state_out;

  int nChecks = 0;
  int nPass   = 0;
  int startCnt = 0;
  int doneCnt  = 0;
  int toCnt    = 0;
  logic [7:0] sbQ [$];
  logic [7:0] expByte;
  logic [7:0] pkt1 [8] = '{8'h02, 8'h03, 8'hA5, 8'h3C, 8'hFF, 8'h12, 8'h34, 8'h56};

  rx_packet_sequencer #(
    .AA_ERR_MAX(2),
    .FIFO_DEPTH(4),
    .MAX_PDU_LEN(37),
    .CRC_BYTES(3),
    .SEARCH_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_enable(i_enable),
    .i_aa_cfg(i_aa_cfg),
    .i_bit_in(i_bit_in),
    .i_bit_strobe(i_bit_strobe),
    .o_byte_out(o_byte_out),
    .o_byte_valid(o_byte_valid),
    .i_byte_ready(i_byte_ready),
    .o_pkt_start(o_pkt_start),
    .o_pkt_done(o_pkt_done),
    .o_pkt_abort(o_pkt_abort),
    .o_search_timeout(o_search_timeout),
    .o_length_err(o_length_err),
    .o_overflow(o_overflow),
    .o_state_out(o_state_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
  endtask

  // Monitor: handshakes seen at negedge complete on the following posedge
  always @(negedge clk) begin
    if (rst) begin
      if (o_pkt_start) startCnt++;
      if (o_pkt_done) doneCnt++;
      if (o_search_timeout) toCnt++;
      if (o_byte_valid && i_byte_ready) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL unexpected_byte: actual 0x%0h required none", o_byte_out);
        end else begin
          expByte = sbQ.pop_front();
          checkOutput("byte_out", {24'd0, o_byte_out}, {24'd0, expByte});
        end
      end
    end
  end

  // One bit with a strobe rising edge; entered and left at posedge+1
  task automatic applyStimulus(input logic b);
    i_bit_in     = b;
    i_bit_strobe = 1'b1;
    @(posedge clk); #1;
    i_bit_strobe = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input bit readyAtLast);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && readyAtLast) i_byte_ready = 1'b1;
      applyStimulus(b[i]);
    end
  endtask

  task automatic sendAA(input logic [31:0] flip);
    logic [31:0] v;
    v = AA ^ flip;
    for (int i = 0; i < 32; i++) applyStimulus(v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic restart();
    i_enable = 1'b0;
    idle(2);
    i_enable = 1'b1;
    idle(2);
  endtask

  task automatic drainCheck(input string name);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, sbQ.size(), 0);
  endtask

  initial begin
    rst          = 1'b0;
    i_enable     = 1'b0;
    i_aa_cfg     = AA;
    i_bit_in     = 1'b0;
    i_bit_strobe = 1'b0;
    i_byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {14'd0, o_byte_out, o_byte_valid, o_pkt_start, o_pkt_done,
                o_pkt_abort, o_search_timeout, o_length_err, o_overflow, o_state_out}, 0);
    rst = 1'b1;
    idle(2);
    checkOutput("idle_state", o_state_out, 0);
    i_enable = 1'b1;
    idle(2);
    checkOutput("search_state", o_state_out, 1);

    // 1: clean packet, 8 bytes out in order
    sendAA(32'h0);
    checkOutput("t1_pkt_start", startCnt, 1);
    checkOutput("t1_state_header", o_state_out, 2);
    for (int i = 0; i < 8; i++) begin
      sbQ.push_back(pkt1[i]);
      sendByte(pkt1[i], 1'b0);
    end
    checkOutput("t1_pkt_done", doneCnt, 1);
    checkOutput("t1_state_search", o_state_out, 1);
    checkOutput("t1_start_once", startCnt, 1);
    drainCheck("t1_bytes_drained");

    // 2: error tolerance on the access address
    restart();
    sendAA(32'h0002_0008);
    checkOutput("t2_two_flip_start", startCnt, 2);
    restart();
    sendAA(32'h2002_0008);
    idle(4);
    checkOutput("t2_three_flip_nostart", startCnt, 2);
    checkOutput("t2_three_flip_state", o_state_out, 1);

    // 3: oversize length
    restart();
    sendAA(32'h0);
    sbQ.push_back(8'h11);
    sendByte(8'h11, 1'b0);
    sbQ.push_back(8'h40);
    sendByte(8'h40, 1'b0);
    checkOutput("t3_length_err", o_length_err, 1);
    checkOutput("t3_pkt_done", doneCnt, 2);
    checkOutput("t3_state_search", o_state_out, 1);
    drainCheck("t3_two_bytes");
    sendAA(32'h0);
    checkOutput("t3_start_again", startCnt, 4);
    checkOutput("t3_length_err_cleared", o_length_err, 0);
    restart();

    // 4: FIFO overflow, then push+pop while full
    i_byte_ready = 1'b0;
    sendAA(32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) sbQ.push_back(pkt1[i]);
      sendByte(pkt1[i], 1'b0);
    end
    checkOutput("t4_overflow", o_overflow, 1);
    checkOutput("t4_pkt_done", doneCnt, 3);
    checkOutput("t4_valid_held", o_byte_valid, 1);
    i_byte_ready = 1'b1;
    drainCheck("t4_four_bytes");
    i_byte_ready = 1'b0;
    sendAA(32'h0);
    checkOutput("t4_overflow_cleared", o_overflow, 0);
    for (int i = 0; i < 8; i++) begin
      sbQ.push_back(pkt1[i]);
      sendByte(pkt1[i], (i == 4));
    end
    checkOutput("t4_full_push_pop_no_overflow", o_overflow, 0);
    checkOutput("t4_pkt_done2", doneCnt, 4);
    drainCheck("t4_eight_bytes");

    // 5: abort mid-payload with bytes held
    i_byte_ready = 1'b0;
    restart();
    sendAA(32'h0);
    sendByte(8'h01, 1'b0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h77, 1'b0);
    repeat (4) applyStimulus(1'b1);
    checkOutput("t5_valid_before_abort", o_byte_valid, 1);
    checkOutput("t5_state_payload", o_state_out, 3);
    i_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_pkt_abort", o_pkt_abort, 1);
    checkOutput("t5_valid_flushed", o_byte_valid, 0);
    checkOutput("t5_state_idle", o_state_out, 0);
    @(posedge clk); #1;
    checkOutput("t5_abort_one_cycle", o_pkt_abort, 0);
    i_byte_ready = 1'b1;
    i_enable     = 1'b1;
    idle(2);

    // 6: search timeout on noise, then reset mid-packet
    checkOutput("t6_no_timeout_before", toCnt, 0);
    restart();
    repeat (63) applyStimulus(1'b0);
    checkOutput("t6_no_timeout_63", toCnt, 0);
    applyStimulus(1'b0);
    checkOutput("t6_timeout_64", toCnt, 1);
    repeat (64) applyStimulus(1'b0);
    checkOutput("t6_timeout_128", toCnt, 2);
    checkOutput("t6_state_search", o_state_out, 1);
    i_byte_ready = 1'b0;
    restart();
    sendAA(32'h0);
    sendByte(8'h05, 1'b0);
    repeat (3) applyStimulus(1'b1);
    checkOutput("t6_valid_before_reset", o_byte_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6_reset_outputs", {14'd0, o_byte_out, o_byte_valid, o_pkt_start, o_pkt_done,
                o_pkt_abort, o_search_timeout, o_length_err, o_overflow, o_state_out}, 0);
    idle(2);
    rst          = 1'b1;
    i_byte_ready = 1'b1;
    idle(4);
    checkOutput("final_sb_empty", sbQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
